// File: rtl/piso_serial_tx_pkg.sv
// Shared types and constants for the serial transmit path.
// Provides the FSM state encoding, bit-order selectors and counter sizing.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam bit MSB = 1'b1;
    localparam bit LSB = 1'b0;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Parallel word handshake plus serial output bundle of the PISO transmitter.
// master = producer/consumer side, slave = transmitter side.
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             q;
    logic             qb;
    logic             q_valid;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, q, qb, q_valid, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, q, qb, q_valid, done
    );
endinterface

// File: rtl/piso_serial_tx_shift_reg.sv
// WIDTH-bit load/shift/clear register; DIR selects which end is the head bit.
// head_nxt_o is the head bit the register will hold after this edge.
module shift_reg_piso
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit DIR   = MSB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             head_nxt_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (clear_i) begin
            sh_d = '0;
        end else if (shift_i) begin
            if (DIR == MSB) begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[WIDTH-1:1]};
            end
        end
    end

    assign head_nxt_o = (DIR == MSB) ? sh_d[WIDTH-1] : sh_d[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per WIDTH cycles, back-to-back capable.
// First bit appears the cycle after accept; din_ready only in IDLE or on the last bit.
module piso_serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    piso_serial_tx_if.slave     bus
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, qb_q, q_valid_q, done_q;
    logic             q_valid_d, done_d;
    logic             load, shift, clear;
    logic             head_nxt;
    logic             ready;
    logic             accept;

    assign ready  = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
    assign accept = bus.din_valid && ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_valid_d = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    cnt_d     = '0;
                    q_valid_d = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // Reload on the last bit keeps the stream gap-free.
                    if (accept) begin
                        load      = 1'b1;
                        cnt_d     = '0;
                        q_valid_d = 1'b1;
                    end else begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    shift     = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    q_valid_d = 1'b1;
                    done_d    = (cnt_q == CNT_PEN);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    shift_reg_piso #(
        .WIDTH (WIDTH),
        .DIR   (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .shift_i    (shift),
        .clear_i    (clear),
        .data_i     (bus.din),
        .head_nxt_o (head_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            q_q       <= 1'b0;
            qb_q      <= 1'b1;
            q_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_q       <= head_nxt;
            qb_q      <= ~head_nxt;
            q_valid_q <= q_valid_d;
            done_q    <= done_d;
        end
    end

    assign bus.din_ready = ready;
    assign bus.q         = q_q;
    assign bus.qb        = qb_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: MSB-first instance driven from a vector table,
// LSB-first instance and reset corner cases driven by hand-written sequences.
module tb_piso_serial_tx;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    piso_serial_tx_if #(.WIDTH(8)) bus_m ();
    piso_serial_tx_if #(.WIDTH(8)) bus_l ();

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       q;
        logic       qv;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    // Record i drives the inputs for the cycle ending at edge i and lists outputs after it.
    function automatic void add_word(input logic [7:0] w, input int vld_from, input logic [7:0] hold);
        vec_t v;
        for (int i = 0; i < 8; i++) begin
            v.vld  = (i == 0) || (i >= vld_from);
            v.din  = (i == 0) ? w : hold;
            v.q    = w[7-i];
            v.qv   = 1'b1;
            v.done = (i == 7);
            v.rdy  = (i == 7);
            tbl.push_back(v);
        end
    endfunction

    function automatic void add_idle();
        vec_t v;
        v.vld = 1'b0; v.din = 8'h00; v.q = 1'b0; v.qv = 1'b0; v.done = 1'b0; v.rdy = 1'b1;
        tbl.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;

        rst = 1'b1;
        bus_m.din = 8'h00; bus_m.din_valid = 1'b0;
        bus_l.din = 8'h00; bus_l.din_valid = 1'b0;

        add_word(8'hA5, 8, 8'h00);
        add_idle();
        add_word(8'hFF, 1, 8'h00);
        add_word(8'h00, 8, 8'h00);
        add_idle();
        add_word(8'h3C, 2, 8'hC3);
        add_word(8'hC3, 8, 8'h00);
        add_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_q",     bus_m.q,       1'b0);
        chk("rst_qb",    bus_m.qb,      1'b1);
        chk("rst_qv",    bus_m.q_valid, 1'b0);
        chk("rst_done",  bus_m.done,    1'b0);
        chk("rst_l_q",   bus_l.q,       1'b0);
        chk("rst_l_qb",  bus_l.qb,      1'b1);
        rst = 1'b0;
        tick();
        chk("post_rst_rdy",   bus_m.din_ready, 1'b1);
        chk("post_rst_l_rdy", bus_l.din_ready, 1'b1);
        chk("post_rst_qv",    bus_m.q_valid,   1'b0);

        foreach (tbl[i]) begin
            bus_m.din_valid = tbl[i].vld;
            bus_m.din       = tbl[i].din;
            tick();
            chk($sformatf("vec%0d_q", i),    bus_m.q,         tbl[i].q);
            chk($sformatf("vec%0d_qb", i),   bus_m.qb,        ~tbl[i].q);
            chk($sformatf("vec%0d_qv", i),   bus_m.q_valid,   tbl[i].qv);
            chk($sformatf("vec%0d_done", i), bus_m.done,      tbl[i].done);
            chk($sformatf("vec%0d_rdy", i),  bus_m.din_ready, tbl[i].rdy);
        end
        bus_m.din_valid = 1'b0;

        // Mid-frame async reset: 8'hF0 aborted while its fourth 1 is on q.
        bus_m.din = 8'hF0; bus_m.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_m.din_valid = 1'b0;
            chk($sformatf("f0_b%0d_q", i),    bus_m.q,    1'b1);
            chk($sformatf("f0_b%0d_done", i), bus_m.done, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q",    bus_m.q,         1'b0);
        chk("arst_qb",   bus_m.qb,        1'b1);
        chk("arst_qv",   bus_m.q_valid,   1'b0);
        chk("arst_done", bus_m.done,      1'b0);
        chk("arst_rdy",  bus_m.din_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("after_arst_qv",   bus_m.q_valid, 1'b0);
        chk("after_arst_done", bus_m.done,    1'b0);

        w = 8'h81;
        bus_m.din = w; bus_m.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus_m.din_valid = 1'b0;
            chk($sformatf("x81_b%0d_q", i),    bus_m.q,       w[7-i]);
            chk($sformatf("x81_b%0d_qv", i),   bus_m.q_valid, 1'b1);
            chk($sformatf("x81_b%0d_done", i), bus_m.done,    i == 7);
        end
        tick();
        chk("x81_end_qv", bus_m.q_valid, 1'b0);

        // LSB-first instance.
        w = 8'h01;
        bus_l.din = w; bus_l.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus_l.din_valid = 1'b0;
            chk($sformatf("lsb_b%0d_q", i),    bus_l.q,         w[i]);
            chk($sformatf("lsb_b%0d_qb", i),   bus_l.qb,        ~w[i]);
            chk($sformatf("lsb_b%0d_qv", i),   bus_l.q_valid,   1'b1);
            chk($sformatf("lsb_b%0d_done", i), bus_l.done,      i == 7);
            chk($sformatf("lsb_b%0d_rdy", i),  bus_l.din_ready, i == 7);
        end
        tick();
        chk("lsb_end_qv", bus_l.q_valid, 1'b0);
        chk("lsb_end_q",  bus_l.q,       1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in/serial-out transmitter that produces the single-bit `d`-style stream consumed by our flip-flop and shift-register stages.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on `q`, with complement `qb`.
- Back-to-back words stream with no idle gap.
- Sits between a parallel producer (counter or register file) and any serial-input sequential block.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  producer presents a valid word on din.
- din_ready  output  1  block can accept a word this cycle.
- q  output  1  serial data bit, registered.
- qb  output  1  complement of q, registered.
- q_valid  output  1  q carries a frame bit this cycle.
- done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shift register=0, bit counter=0.
  - q=0, qb=1, q_valid=0, done=0.
  - din_ready=1 from the first cycle after release.
- FSM states: IDLE and SHIFT.
- Handshake:
  - A word is accepted on a rising edge where din_valid && din_ready.
  - din_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). This is combinational from state; it never depends on din_valid.
  - din is sampled only on the accept edge. Later changes to din do not affect the word in flight.
- IDLE -> SHIFT on accept:
  - Load the shift register, set cnt=0.
  - At the same edge, q <= first bit and q_valid <= 1.
- Latency: for a word accepted at edge k, bit i appears on q during cycles k+1 .. k+WIDTH. That is WIDTH cycles per word.
- SHIFT operation:
  - Each edge advances to the next bit (left shift if MSB_FIRST, right shift otherwise) and increments cnt.
  - cnt width is $clog2(WIDTH).
  - done=1 exactly while the last bit is on q (cnt==WIDTH-1), registered alongside q.
- End of word (cnt==WIDTH-1), at the next edge:
  - With an accept: load the new word. The first bit follows the previous last bit with no gap and q_valid stays 1. Stay in SHIFT, cnt=0.
  - Without an accept: go to IDLE with q=0, qb=1, q_valid=0.
- qb is always ~q, including during reset.
- din_valid while din_ready=0 is ignored. Nothing is queued and there is no error flag. The producer must hold din_valid.
- Reset mid-frame aborts the word immediately. Outputs take reset values asynchronously and there is no partial retransmission.
- There is no backpressure on the serial side; the receiver must sample every cycle q_valid=1.

Decomposition:
- Shared package `serial_pkg`:
  - state enum {IDLE, SHIFT}.
  - localparam CNT_W = $clog2(WIDTH) helper.
  - Bit-order constants MSB/LSB.
- One natural sub-module: `shift_reg_piso`, a WIDTH-bit load/shift register with a direction parameter.
- The top level holds the FSM, counter and handshake.

Test Plan (WIDTH=8 unless noted):
- Reset: hold rst=1 for 3 cycles, with clk toggling every 5 ns. Require q=0, qb=1, q_valid=0, done=0, din_ready=1. Assert rst asynchronously between edges and check outputs change before the next edge.
- Single word, MSB_FIRST=1: din=8'hA5 with valid for one accept. Require q = 1,0,1,0,0,1,0,1 over the next 8 cycles, q_valid=1 throughout, done=1 only on the 8th bit, din_ready=0 for bits 1-7, then IDLE.
- LSB_FIRST: MSB_FIRST=0, din=8'h01. Require q = 1,0,0,0,0,0,0,0 and qb the complement on every cycle.
- Back-to-back: din_valid held high with 8'hFF then 8'h00. Require 16 contiguous q_valid cycles, q = eight 1s then eight 0s, done pulsing at cycles 8 and 16, and the second accept landing on the last-bit cycle of the first word.
- Ignored request: din=8'h3C accepted, then din changed to 8'hC3 with din_valid=1 at bit 3. Require the transmitted stream to be 0,0,1,1,1,1,0,0, then 8'hC3 accepted only at the last-bit cycle.
- Reset mid-frame: rst asserted at bit 4 of 8'hF0. Require immediate q=0, q_valid=0, done never asserted for that word, and a clean 8'h81 transfer after release.
